// File: rtl/test_sched_if.sv
// Signal bundle between the NoC test-window scheduler (master) and the router
// detect logic (slave).
interface test_sched_if #(
    parameter int NUM_NODE = 8
);
    logic                start;
    logic [NUM_NODE-1:0] border_done;
    logic                test_set;
    logic [1:0]          phase;
    logic [NUM_NODE-1:0] slot_grant;
    logic                busy;
    logic                done;
    logic [NUM_NODE-1:0] timeout_vec;

    modport master (
        input  start, border_done,
        output test_set, phase, slot_grant, busy, done, timeout_vec
    );

    modport slave (
        output start, border_done,
        input  test_set, phase, slot_grant, busy, done, timeout_vec
    );
endinterface

// File: rtl/test_sched.sv
// Central sequencer for the NoC fault-detection window: TD, ACK, per-router border slots, guard.
// Define TEST_TIMEOUT_FLAG_EN to build the per-router slot-timeout flags.
module test_sched #(
    parameter int NUM_NODE     = 8,
    parameter int TD_CYCLES    = 6,
    parameter int ACK_CYCLES   = 70,
    parameter int SLOT_CYCLES  = 2,
    parameter int GUARD_CYCLES = 10
) (
    input  logic         clk,
    input  logic         reset,
    test_sched_if.master bus
);
    localparam int IDX_W = $clog2(NUM_NODE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TD     = 3'd1;
    localparam logic [2:0] S_ACK    = 3'd2;
    localparam logic [2:0] S_BORDER = 3'd3;
    localparam logic [2:0] S_GUARD  = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [7:0]       TD_LAST    = 8'(TD_CYCLES - 1);
    localparam logic [7:0]       ACK_LAST   = 8'(ACK_CYCLES - 1);
    localparam logic [7:0]       SLOT_LAST  = 8'(SLOT_CYCLES - 1);
    localparam logic [7:0]       GUARD_LAST = 8'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_NODE - 1);

    logic [2:0]          state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                test_set_q, test_set_d;
    logic [1:0]          phase_q, phase_d;
    logic [NUM_NODE-1:0] slot_grant_q, slot_grant_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                slot_done, slot_expired;

    assign slot_done    = bus.border_done[idx_q];
    assign slot_expired = (cnt_q == SLOT_LAST);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start) state_d = S_TD;
            end
            S_TD: begin
                if (cnt_q == TD_LAST) begin
                    state_d = S_ACK;
                    cnt_d   = '0;
                end
            end
            S_ACK: begin
                if (cnt_q == ACK_LAST) begin
                    state_d = S_BORDER;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_BORDER: begin
                // A slot ends on its router's done bit or on expiry, whichever comes first.
                if (slot_done || slot_expired) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_GUARD;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = S_FINISH;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered values line up with the state.
    always_comb begin
        test_set_d   = (state_d == S_TD) || (state_d == S_ACK) ||
                       (state_d == S_BORDER) || (state_d == S_GUARD);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_FINISH);
        slot_grant_d = '0;
        phase_d      = 2'd0;
        case (state_d)
            S_ACK:    phase_d = 2'd1;
            S_BORDER: begin
                phase_d      = 2'd2;
                slot_grant_d = NUM_NODE'(1) << idx_d;
            end
            S_GUARD:  phase_d = 2'd3;
            default:  phase_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            test_set_q   <= 1'b0;
            phase_q      <= 2'd0;
            slot_grant_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            test_set_q   <= test_set_d;
            phase_q      <= phase_d;
            slot_grant_q <= slot_grant_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.test_set   = test_set_q;
    assign bus.phase      = phase_q;
    assign bus.slot_grant = slot_grant_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

`ifdef TEST_TIMEOUT_FLAG_EN
    logic [NUM_NODE-1:0] timeout_q, timeout_d;

    always_comb begin
        timeout_d = timeout_q;
        if (state_q == S_IDLE && bus.start) begin
            timeout_d = '0;
        end else if (state_q == S_BORDER && slot_expired && !slot_done) begin
            timeout_d[idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) timeout_q <= '0;
        else        timeout_q <= timeout_d;
    end

    assign bus.timeout_vec = timeout_q;
`else
    assign bus.timeout_vec = '0;
`endif
endmodule

// File: tb/tb_test_sched.sv
// Self-checking bench for test_sched: a timeline model of each run (slot start cycles
// derived from per-router completion delays) is compared with the DUT every cycle.
module tb_test_sched;
    localparam int NUM_NODE = 8;
    localparam int TD       = 6;
    localparam int ACK      = 70;
    localparam int SLOT     = 2;
    localparam int GUARD    = 10;
    localparam int S_NODE   = 2;
    localparam int S_SLOT   = 1;
`ifdef TEST_TIMEOUT_FLAG_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic                ts;
        logic [1:0]          ph;
        logic [NUM_NODE-1:0] gr;
        logic                by;
        logic                dn;
        logic [NUM_NODE-1:0] to;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    test_sched_if #(.NUM_NODE(NUM_NODE)) bus ();
    test_sched_if #(.NUM_NODE(S_NODE))   sbus ();

    test_sched #(
        .NUM_NODE(NUM_NODE), .TD_CYCLES(TD), .ACK_CYCLES(ACK),
        .SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    test_sched #(
        .NUM_NODE(S_NODE), .TD_CYCLES(TD), .ACK_CYCLES(ACK),
        .SLOT_CYCLES(S_SLOT), .GUARD_CYCLES(GUARD)
    ) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Run plan: router i raises border_done on the dly[i]-th cycle of its slot (> SLOT: never).
    int dly [NUM_NODE];
    int slot_start [NUM_NODE+1];
    int fin;

    task automatic plan(input int mode);
        for (int i = 0; i < NUM_NODE; i++) begin
            if (mode == 0)      dly[i] = SLOT + 1;
            else if (mode == 1) dly[i] = 1;
            else                dly[i] = int'($urandom_range(SLOT + 1, 1));
        end
        slot_start[0] = TD + ACK + 1;
        for (int i = 0; i < NUM_NODE; i++)
            slot_start[i+1] = slot_start[i] + ((dly[i] < SLOT) ? dly[i] : SLOT);
        fin = slot_start[NUM_NODE] + GUARD;
    endtask

    // Expected outputs in cycle c, where cycle 1 follows the edge that sampled start.
    function automatic obs_t model(input int c);
        obs_t e;
        e = '0;
        if (c >= 1 && c < fin) begin
            e.ts = 1'b1;
            e.by = 1'b1;
            if (c <= TD)                       e.ph = 2'd0;
            else if (c <= TD + ACK)            e.ph = 2'd1;
            else if (c < slot_start[NUM_NODE]) begin
                e.ph = 2'd2;
                for (int i = 0; i < NUM_NODE; i++)
                    if (c >= slot_start[i] && c < slot_start[i+1]) e.gr[i] = 1'b1;
            end else                           e.ph = 2'd3;
        end else if (c == fin) begin
            e.by = 1'b1;
            e.dn = 1'b1;
        end
        if (TO_EN)
            for (int i = 0; i < NUM_NODE; i++)
                if (dly[i] > SLOT && c >= slot_start[i+1]) e.to[i] = 1'b1;
        return e;
    endfunction

    // noise: 0 = idle bits low, 1 = idle bits high, 2 = idle bits random.
    function automatic logic [NUM_NODE-1:0] drive_bd(input int c, input int noise);
        logic [NUM_NODE-1:0] v;
        if (noise == 1)      v = '1;
        else if (noise == 2) v = NUM_NODE'($urandom);
        else                 v = '0;
        for (int i = 0; i < NUM_NODE; i++)
            if (c >= slot_start[i] && c < slot_start[i+1])
                v[i] = ((c - slot_start[i] + 1) == dly[i]);
        return v;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a.ts = bus.test_set;
        a.ph = bus.phase;
        a.gr = bus.slot_grant;
        a.by = bus.busy;
        a.dn = bus.done;
        a.to = bus.timeout_vec;
        return a;
    endfunction

    // Starts a run in the current (IDLE) cycle and checks every cycle through the first IDLE
    // cycle afterwards; abort_at > 0 pulls reset in that cycle instead.
    task automatic do_run(input string name, input int noise, input int abort_at);
        obs_t act, exp;
        bus.start       = 1'b1;
        bus.border_done = drive_bd(0, noise);
        for (int c = 1; c <= fin + 1; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                #1 reset = 1'b0;
                #1;
                act = sample();
                exp = '0;
                vectors++;
                if (act !== exp) begin
                    miscompares++;
                    $display("FAIL %s reset cycle %0d: got %h expected %h", name, c, act, exp);
                end
                bus.start       = 1'b0;
                bus.border_done = '0;
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            act = sample();
            exp = model(c);
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got ts=%b ph=%0d gr=%b busy=%b done=%b to=%b, expected ts=%b ph=%0d gr=%b busy=%b done=%b to=%b",
                         name, c, act.ts, act.ph, act.gr, act.by, act.dn, act.to,
                         exp.ts, exp.ph, exp.gr, exp.by, exp.dn, exp.to);
            end
            if (c == 40 || c == fin)     bus.start = 1'b1;
            else if (noise == 2 && c < fin) bus.start = 1'($urandom_range(1, 0));
            else                         bus.start = 1'b0;
            bus.border_done = drive_bd(c, noise);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        obs_t act;
        bus.start        = 1'b1;
        bus.border_done  = '1;
        sbus.start       = 1'b0;
        sbus.border_done = '0;
        reset            = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            act = sample();
            vectors++;
            if (act !== obs_t'(0)) begin
                miscompares++;
                $display("FAIL reset_hold: got %h expected 0", act);
            end
        end
        bus.start = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        act = sample();
        vectors++;
        if (act !== obs_t'(0)) begin
            miscompares++;
            $display("FAIL reset_release_idle: got %h expected 0", act);
        end
    endtask

    task automatic test_nominal();
        plan(0);
        do_run("nominal", 1, 0);
    endtask

    task automatic test_all_done();
        plan(1);
        do_run("all_done", 1, 0);
    endtask

    task automatic test_back_to_back_random();
        for (int r = 0; r < 6; r++) begin
            plan(2);
            do_run("random", 2, 0);
        end
    endtask

    task automatic test_reset_mid_run();
        plan(0);
        do_run("abort", 1, 50);
        plan(0);
        do_run("after_abort", 0, 0);
    endtask

    task automatic test_small_node();
        localparam int B0 = TD + ACK + 1;
        localparam int F  = TD + ACK + S_NODE * S_SLOT + GUARD + 1;
        logic [8:0] act, exp;
        logic       ets, eby, edn;
        logic [1:0] eph, egr, eto;
        sbus.start       = 1'b1;
        sbus.border_done = '0;
        for (int c = 1; c <= F + 1; c++) begin
            @(negedge clk);
            sbus.start = 1'b0;
            ets = (c < F);
            eby = (c <= F);
            edn = (c == F);
            if (!ets)                 eph = 2'd0;
            else if (c <= TD)         eph = 2'd0;
            else if (c <= TD + ACK)   eph = 2'd1;
            else if (c < B0 + S_NODE) eph = 2'd2;
            else                      eph = 2'd3;
            egr = (c == B0) ? 2'b01 : (c == B0 + 1) ? 2'b10 : 2'b00;
            eto = TO_EN ? {c >= B0 + 2, c >= B0 + 1} : 2'b00;
            exp = {ets, eph, egr, eby, edn, eto};
            act = {sbus.test_set, sbus.phase, sbus.slot_grant, sbus.busy, sbus.done, sbus.timeout_vec};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL small_node cycle %0d: got %b expected %b (ts,ph,gr,busy,done,to)", c, act, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_all_done();
        test_back_to_back_random();
        test_reset_mid_run();
        test_small_node();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/test_sched.md
# test_sched

Central scheduler for the NoC fault-detection test window. It replaces the per-router free-running test counters with one sequencer. The sequencer holds the global `test_set` high and steps all routers through three phases: status exchange (TD), acknowledge (ACK), and per-router border check. Border-check slots are granted one router at a time, in router-ID order; a router may finish its slot early. The block sits at the top of the hypercube mesh and fans `test_set`, `phase` and `slot_grant` out to every router's detect logic.

## Interface
- `NUM_NODE`, 8: number of routers; range 2–16.
- `TD_CYCLES`, 6: length of TD phase in cycles; range 1–255.
- `ACK_CYCLES`, 70: length of ACK phase in cycles; range 1–255.
- `SLOT_CYCLES`, 2: maximum length of one border slot in cycles; range 1–255.
- `GUARD_CYCLES`, 10: cycles `test_set` stays high after the last slot; range 1–255.
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request a test run; sampled only in IDLE.
- `border_done` in NUM_NODE: router i has finished its border check; honoured only while `slot_grant[i]`=1.
- `test_set` out 1: global test-mode enable; high from TD through GUARD.
- `phase` out 2: 0=TD, 1=ACK, 2=BORDER, 3=GUARD; reads 0 whenever `test_set`=0.
- `slot_grant` out NUM_NODE: one-hot border-slot grant; all zero outside BORDER.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a run completes.
- `timeout_vec` out NUM_NODE: per-router slot-expired flags (see Configuration).

## Operation
- States: IDLE, TD, ACK, BORDER, GUARD, FINISH.
- All outputs are registered. Reset value of every output is 0. Counter and slot index reset to 0.
- IDLE: on `start`=1, go to TD and clear the counter and `timeout_vec`. `start` in any other state is ignored and is not queued.
- TD: stay for TD_CYCLES cycles, then go to ACK.
- ACK: stay for ACK_CYCLES cycles, then go to BORDER with slot index 0.
- BORDER: `slot_grant[idx]`=1. The slot ends on the first of two events:
  - `border_done[idx]`=1;
  - the slot counter reaching SLOT_CYCLES.
- When a slot ends, idx increments. After idx = NUM_NODE-1, go to GUARD.
- GUARD: stay for GUARD_CYCLES cycles, then go to FINISH.
- FINISH: one cycle. `test_set`=0, `done`=1, `busy`=1. Then go to IDLE.
- One 8-bit phase counter is cleared on every state change. Comparisons are unsigned against the parameter minus 1. There is no wrap-around, because the parameters are bounded to 255.
- Slot index is ceil(log2(NUM_NODE)) bits wide. It never exceeds NUM_NODE-1.
- `border_done` bits for routers that are not granted are ignored, including in non-BORDER states.
- If `border_done[idx]` and slot expiry happen in the same cycle, the slot counts as done and no timeout is flagged.
- When `reset` is asserted mid-run, all outputs go to 0 immediately and the state goes to IDLE. No `done` pulse is produced.

## Timing
- `start` high at edge t gives `test_set`=1, `phase`=0, `busy`=1 from t+1.
- ACK begins at t+1+TD_CYCLES. BORDER begins at t+1+TD_CYCLES+ACK_CYCLES.
- Each slot occupies 1..SLOT_CYCLES cycles. When `border_done` is high at edge e, the grant moves to the next router at e+1. There are no gap cycles between slots.
- With no early completion, `test_set` stays high for TD_CYCLES+ACK_CYCLES+NUM_NODE·SLOT_CYCLES+GUARD_CYCLES cycles, then `done` pulses for one cycle.
- The earliest restart is a `start` sampled in the cycle after FINISH, i.e. in IDLE.

## Configuration
- `TEST_TIMEOUT_FLAG_EN` defined:
  - When a slot ends by expiry without `border_done`, `timeout_vec[idx]` is set to 1.
  - Flags hold through IDLE and clear on the next accepted `start` or on reset.
- `TEST_TIMEOUT_FLAG_EN` not defined: `timeout_vec` is tied to 0 and no flag registers are built.

## Test plan
- Defaults, `start` pulse at cycle 0, `border_done`=0 → `test_set` high for cycles 1–102 (102 cycles); `phase` 0 for cycles 1–6, 1 for 7–76, 2 for 77–92, 3 for 93–102; `done`=1 at cycle 103; with the macro, `timeout_vec`=8'hFF.
- Defaults, `border_done[i]` held high for all i → each slot lasts 1 cycle; BORDER spans cycles 77–84; `done` at cycle 95; `timeout_vec`=0.
- `border_done[3]`=1 while `slot_grant[1]` is active → ignored; slot 1 runs the full 2 cycles; `timeout_vec[1]`=1 with the macro.
- Second `start` pulse at cycle 40 of a run → no effect; `done` still at cycle 103, and only one `done` pulse.
- `reset` driven low at cycle 50 → `test_set`, `busy`, `phase` and `slot_grant` read 0 in that cycle; after release, a new `start` reproduces the full 102-cycle window.
- NUM_NODE=2, SLOT_CYCLES=1 → grants 2'b01 then 2'b10, one cycle each; `test_set` high for 6+70+2+10=88 cycles.
